// File: rtl/rv_pkg.sv
// Shared register-file writeback types and constants.
package rv_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // One register-file write: destination register plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Source feeding the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_HOLD = 2'd2,
        SRC_LOAD = 2'd3
    } wb_src_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of outstanding load destination registers.
// Pointers wrap naturally because DEPTH is a power of two.
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; contents are don't-care until pushed, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: merges ALU results and in-order load responses onto
// the single register-file write port and tracks pending loads per register.
module wb_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LD_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alu_valid,
    input  logic [ADDR_W-1:0] i_alu_rd,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_ld_issue,
    input  logic [ADDR_W-1:0] i_ld_rd,
    output logic              o_ld_ready,
    input  logic              i_ld_rsp_valid,
    input  logic [DATA_W-1:0] i_ld_rsp_data,
    output logic              o_ld_rsp_ready,
    input  logic [ADDR_W-1:0] i_chk_rs1,
    input  logic [ADDR_W-1:0] i_chk_rs2,
    input  logic [ADDR_W-1:0] i_chk_rd,
    output logic              o_hazard,
    output logic              o_rd_wren,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [31:0]       o_busy,
    output logic              o_err
);

    import rv_pkg::wb_req_t;
    import rv_pkg::wb_src_t;
    import rv_pkg::SRC_NONE;
    import rv_pkg::SRC_ALU;
    import rv_pkg::SRC_HOLD;
    import rv_pkg::SRC_LOAD;
    import rv_pkg::NUM_REGS;

    localparam int CNT_W = $clog2(LD_DEPTH) + 1;

    logic [NUM_REGS-1:0] r_busy;
    wb_req_t             r_hold;
    logic                r_hold_full;
    wb_req_t             r_wr;
    logic                r_wren;
    logic                r_err;

    logic [ADDR_W-1:0]   w_head_rd;
    logic [CNT_W-1:0]    w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_ld_ready;
    logic                w_issue;
    logic                w_push;
    logic                w_rsp_acc;
    logic                w_pop;
    logic                w_orphan;
    logic                w_alu_clash;
    wb_req_t             w_paired;
    wb_src_t             w_src;
    wb_req_t             w_sel;
    logic                w_sel_valid;
    logic                w_retire;
    logic                w_hold_load;
    logic                w_hold_clear;
    logic [NUM_REGS-1:0] w_busy_set;
    logic [NUM_REGS-1:0] w_busy_clr;

    tag_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (i_ld_rd),
        .o_rdata (w_head_rd),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A nonzero rd may have only one load in flight, so a pending bit blocks reissue.
    assign w_ld_ready  = (int'(w_count) < LD_DEPTH) &&
                         !((i_ld_rd != '0) && r_busy[i_ld_rd]);
    assign w_issue     = i_ld_issue && w_ld_ready;
    assign w_push      = w_issue && !w_full;
    assign w_rsp_acc   = i_ld_rsp_valid && !r_hold_full;
    assign w_pop       = w_rsp_acc && !w_empty;
    assign w_orphan    = w_rsp_acc && w_empty;
    assign w_alu_clash = i_alu_valid && (i_alu_rd != '0) && r_busy[i_alu_rd];
    assign w_paired    = {w_head_rd, i_ld_rsp_data};

    assign o_ld_ready     = w_ld_ready;
    assign o_ld_rsp_ready = !r_hold_full;
    assign o_hazard       = ((i_chk_rs1 != '0) && r_busy[i_chk_rs1]) ||
                            ((i_chk_rs2 != '0) && r_busy[i_chk_rs2]) ||
                            ((i_chk_rd  != '0) && r_busy[i_chk_rd]);
    assign o_rd_wren      = r_wren;
    assign o_rd_addr      = r_wr.rd;
    assign o_rd_data      = r_wr.data;
    assign o_busy         = r_busy;
    assign o_err          = r_err;

    // Fixed-priority arbitration: ALU first, then the parked load, then a fresh response.
    always_comb begin
        w_src        = SRC_NONE;
        w_hold_load  = 1'b0;
        w_hold_clear = 1'b0;
        if (i_alu_valid) begin
            w_src       = SRC_ALU;
            w_hold_load = w_pop;
        end else if (r_hold_full) begin
            w_src        = SRC_HOLD;
            w_hold_clear = 1'b1;
            w_hold_load  = w_pop;
        end else if (w_pop) begin
            w_src = SRC_LOAD;
        end
    end

    // Select the write-port payload and note whether it retires a load.
    always_comb begin
        w_sel       = '0;
        w_sel_valid = 1'b0;
        w_retire    = 1'b0;
        case (w_src)
            SRC_ALU: begin
                w_sel       = {i_alu_rd, i_alu_data};
                w_sel_valid = 1'b1;
            end
            SRC_HOLD: begin
                w_sel       = r_hold;
                w_sel_valid = 1'b1;
                w_retire    = 1'b1;
            end
            SRC_LOAD: begin
                w_sel       = w_paired;
                w_sel_valid = 1'b1;
                w_retire    = 1'b1;
            end
            default: begin
                w_sel       = '0;
                w_sel_valid = 1'b0;
                w_retire    = 1'b0;
            end
        endcase
    end

    // Scoreboard set/clear masks; x0 is never marked pending.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (w_push && (i_ld_rd != '0)) begin
            w_busy_set = NUM_REGS'(1) << i_ld_rd;
        end
        if (w_retire && (w_sel.rd != '0)) begin
            w_busy_clr = NUM_REGS'(1) << w_sel.rd;
        end
    end

    // Scoreboard: a bit clears in the same cycle its load write is selected.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    // Hold register parks a load response that lost arbitration to the ALU.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_hold_load) begin
            r_hold      <= w_paired;
            r_hold_full <= 1'b1;
        end else if (w_hold_clear) begin
            r_hold_full <= 1'b0;
        end
    end

    // Registered write port; writes aimed at x0 are suppressed.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wren <= 1'b0;
            r_wr   <= '0;
        end else begin
            r_wren <= w_sel_valid && (w_sel.rd != '0);
            if (w_sel_valid) begin
                r_wr <= w_sel;
            end
        end
    end

    // Sticky protocol error: orphan responses or ALU writes to a pending register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else if (w_orphan || w_alu_clash) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed testbench for the writeback controller.
module tb_wb_ctrl;

    logic        clk;
    logic        resetN;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldIssue;
    logic [4:0]  ldRd;
    logic        ldReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspReady;
    logic [4:0]  chkRs1;
    logic [4:0]  chkRs2;
    logic [4:0]  chkRd;
    logic        hazard;
    logic        rdWren;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic [31:0] busy;
    logic        err;

    int assertionsEvaluated = 0;
    int failures = 0;

    wb_ctrl #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .LD_DEPTH (4)
    ) dut (
        .i_clk          (clk),
        .i_reset        (resetN),
        .i_alu_valid    (aluValid),
        .i_alu_rd       (aluRd),
        .i_alu_data     (aluData),
        .i_ld_issue     (ldIssue),
        .i_ld_rd        (ldRd),
        .o_ld_ready     (ldReady),
        .i_ld_rsp_valid (rspValid),
        .i_ld_rsp_data  (rspData),
        .o_ld_rsp_ready (rspReady),
        .i_chk_rs1      (chkRs1),
        .i_chk_rs2      (chkRs2),
        .i_chk_rd       (chkRd),
        .o_hazard       (hazard),
        .o_rd_wren      (rdWren),
        .o_rd_addr      (rdAddr),
        .o_rd_data      (rdData),
        .o_busy         (busy),
        .o_err          (err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every datapath input for the coming cycle.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic li, input logic [4:0] lrd,
                                 input logic rv, input logic [31:0] rdat);
        aluValid = av;
        aluRd    = ard;
        aluData  = adata;
        ldIssue  = li;
        ldRd     = lrd;
        rspValid = rv;
        rspData  = rdat;
    endtask

    // Let one rising edge happen, then return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionsEvaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, ALU, loads, collisions, full FIFO and errors.
    initial begin
        resetN = 1'b0;
        chkRs1 = '0;
        chkRs2 = '0;
        chkRd  = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset_wren",     32'(rdWren),   0);
        checkOutput("reset_addr",     32'(rdAddr),   0);
        checkOutput("reset_data",     rdData,        0);
        checkOutput("reset_busy",     busy,          0);
        checkOutput("reset_err",      32'(err),      0);
        checkOutput("reset_ldready",  32'(ldReady),  1);
        checkOutput("reset_rspready", 32'(rspReady), 1);
        resetN = 1'b1;
        step();

        $display("[TB] ALU writeback");
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step();
        checkOutput("alu_wren", 32'(rdWren), 1);
        checkOutput("alu_addr", 32'(rdAddr), 5);
        checkOutput("alu_data", rdData, 32'hDEADBEEF);
        applyStimulus(1, 0, 32'h1, 0, 0, 0, 0);
        step();
        checkOutput("alu_x0_wren", 32'(rdWren), 0);

        $display("[TB] Single load");
        applyStimulus(0, 0, 0, 1, 7, 0, 0);
        #1;
        checkOutput("ld7_ready", 32'(ldReady), 1);
        step();
        checkOutput("ld7_busy", busy, 32'h80);
        checkOutput("ld7_nowrite", 32'(rdWren), 0);
        applyStimulus(0, 0, 0, 0, 7, 0, 0);
        chkRs1 = 7;
        #1;
        checkOutput("ld7_hazard_rs1", 32'(hazard), 1);
        checkOutput("ld7_dup_blocked", 32'(ldReady), 0);
        chkRs1 = 8;
        #1;
        checkOutput("ld7_nohazard_rs1_8", 32'(hazard), 0);
        chkRd = 7;
        #1;
        checkOutput("ld7_hazard_rd", 32'(hazard), 1);
        chkRd = 0;
        chkRs1 = 0;
        step();
        step();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234);
        step();
        checkOutput("ld7_wren", 32'(rdWren), 1);
        checkOutput("ld7_addr", 32'(rdAddr), 7);
        checkOutput("ld7_data", rdData, 32'h1234);
        checkOutput("ld7_busy_clear", busy, 0);

        $display("[TB] ALU vs load collision");
        applyStimulus(0, 0, 0, 1, 9, 0, 0);
        step();
        applyStimulus(1, 3, 32'hA, 0, 0, 1, 32'hB);
        #1;
        checkOutput("col_rspready_before", 32'(rspReady), 1);
        step();
        checkOutput("col_alu_addr", 32'(rdAddr), 3);
        checkOutput("col_alu_data", rdData, 32'hA);
        checkOutput("col_rspready_held", 32'(rspReady), 0);
        checkOutput("col_busy_held", busy, 32'h200);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("col_ld_wren", 32'(rdWren), 1);
        checkOutput("col_ld_addr", 32'(rdAddr), 9);
        checkOutput("col_ld_data", rdData, 32'hB);
        checkOutput("col_busy_clear", busy, 0);
        checkOutput("col_rspready_after", 32'(rspReady), 1);

        $display("[TB] Full tag FIFO");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 1, 5'(i), 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 5, 0, 0);
        #1;
        checkOutput("full_ldready", 32'(ldReady), 0);
        checkOutput("full_busy", busy, 32'h1E);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 5, 1, 32'h100 + 32'(i));
            step();
            checkOutput("full_ret_addr", 32'(rdAddr), 32'(i));
            checkOutput("full_ret_data", rdData, 32'h100 + 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 5, 0, 0);
        #1;
        checkOutput("full_drained_ready", 32'(ldReady), 1);
        checkOutput("full_drained_busy", busy, 0);

        $display("[TB] Duplicate rd");
        applyStimulus(0, 0, 0, 1, 6, 0, 0);
        step();
        #1;
        checkOutput("dup_blocked", 32'(ldReady), 0);
        step();
        step();
        applyStimulus(0, 0, 0, 1, 6, 1, 32'h66);
        #1;
        checkOutput("dup_blocked_at_retire", 32'(ldReady), 0);
        step();
        checkOutput("dup_ret_addr", 32'(rdAddr), 6);
        checkOutput("dup_ret_data", rdData, 32'h66);
        checkOutput("dup_busy_clear", busy, 0);
        applyStimulus(0, 0, 0, 1, 6, 0, 0);
        #1;
        checkOutput("dup_ready_next", 32'(ldReady), 1);
        step();
        checkOutput("dup_reissued_busy", busy, 32'h40);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h67);
        step();
        checkOutput("dup2_data", rdData, 32'h67);
        checkOutput("dup2_busy", busy, 0);

        $display("[TB] Issue and retire of different rd");
        applyStimulus(0, 0, 0, 1, 10, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 11, 1, 32'hAA);
        step();
        checkOutput("diff_addr", 32'(rdAddr), 10);
        checkOutput("diff_busy", busy, 32'h800);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBB);
        step();
        checkOutput("diff2_addr", 32'(rdAddr), 11);
        checkOutput("diff2_busy", busy, 0);

        $display("[TB] Load to x0");
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step();
        checkOutput("x0_busy", busy, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h55);
        step();
        checkOutput("x0_wren", 32'(rdWren), 0);
        checkOutput("x0_err", 32'(err), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] Reset mid-operation and orphan response");
        applyStimulus(0, 0, 0, 1, 12, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 13, 0, 0);
        step();
        checkOutput("pre_reset_busy", busy, 32'h3000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        resetN = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_wren", 32'(rdWren), 0);
        step();
        resetN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h99);
        step();
        checkOutput("orphan_err", 32'(err), 1);
        checkOutput("orphan_wren", 32'(rdWren), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("orphan_err_sticky", 32'(err), 1);
        resetN = 1'b0;
        #1;
        checkOutput("err_cleared_by_reset", 32'(err), 0);
        step();
        resetN = 1'b1;
        step();

        $display("[TB] ALU write to pending register");
        applyStimulus(0, 0, 0, 1, 14, 0, 0);
        step();
        applyStimulus(1, 14, 32'h77, 0, 0, 0, 0);
        step();
        checkOutput("clash_wren", 32'(rdWren), 1);
        checkOutput("clash_data", rdData, 32'h77);
        checkOutput("clash_err", 32'(err), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assertionsEvaluated, failures);
        $finish;
    end

endmodule
